// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: control-field
// layout, per-stage data widths and the elastic stage state encoding.
package mips_pipe_pkg;

  // Control field bit positions; ALUctr is the only multi-bit field and sits on top
  localparam int CTRL_ALUSRC_BIT   = 0;
  localparam int CTRL_MEMTOREG_BIT = 1;
  localparam int CTRL_REGWRITE_BIT = 2;
  localparam int CTRL_MEMWRITE_BIT = 3;
  localparam int CTRL_NPCSEL_BIT   = 4;
  localparam int CTRL_JMP_BIT      = 5;
  localparam int CTRL_ALUCTR_LSB   = 6;
  localparam int CTRL_ALUCTR_W     = 2;
  localparam int CTRL_W_DEFAULT    = CTRL_ALUCTR_LSB + CTRL_ALUCTR_W;

  localparam int DATA_W_IDEX  = 32 + 32 + 32 + 32 + 5;
  localparam int DATA_W_EXMEM = 32 + 32 + 32 + 5;
  localparam int DATA_W_MEMWB = 32 + 32 + 5;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag, control field and data field.
// Clear drops valid and zeroes ctrl so a bubble never carries live controls.
module pipe_entry_reg
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = DATA_W_IDEX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load; data is left untouched on clear since it is don't-care
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and optional skid entry.
// The FSM steers a main entry (always presented downstream) and a skid entry.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = DATA_W_IDEX,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e r_state;
  logic         r_inReady;

  stage_state_e      w_nextState;
  logic              w_accept;
  logic              w_deliver;
  logic              w_mainLoad;
  logic              w_mainFromSkid;
  logic              w_mainClear;
  logic              w_skidLoad;
  logic              w_skidClear;
  logic              w_mainValid;
  logic              w_skidValid;
  logic [CTRL_W-1:0] w_mainCtrl;
  logic [CTRL_W-1:0] w_skidCtrl;
  logic [DATA_W-1:0] w_mainData;
  logic [DATA_W-1:0] w_skidData;
  logic [CTRL_W-1:0] w_mainCtrlIn;
  logic [DATA_W-1:0] w_mainDataIn;

  // Without a skid entry FULL never advances to SKIDDED because in_ready drops first
  assign in_ready  = (SKID != 0) ? r_inReady : (!w_mainValid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = w_mainValid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != ST_SKIDDED);
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_mainLoad     = 1'b0;
    w_mainFromSkid = 1'b0;
    w_mainClear    = 1'b0;
    w_skidLoad     = 1'b0;
    w_skidClear    = 1'b0;
    if (flush) begin
      w_nextState = ST_EMPTY;
      w_mainClear = 1'b1;
      w_skidClear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_mainLoad  = 1'b1;
            w_nextState = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && !w_deliver) begin
            w_skidLoad  = 1'b1;
            w_nextState = ST_SKIDDED;
          end else if (w_accept && w_deliver) begin
            w_mainLoad = 1'b1;
          end else if (w_deliver) begin
            w_mainClear = 1'b1;
            w_nextState = ST_EMPTY;
          end
        end
        ST_SKIDDED: begin
          if (w_deliver) begin
            w_mainLoad     = 1'b1;
            w_mainFromSkid = 1'b1;
            w_skidClear    = 1'b1;
            w_nextState    = ST_FULL;
          end
        end
        default: begin
          w_nextState = ST_EMPTY;
          w_mainClear = 1'b1;
          w_skidClear = 1'b1;
        end
      endcase
    end
  end

  assign w_mainCtrlIn = w_mainFromSkid ? w_skidCtrl : in_ctrl;
  assign w_mainDataIn = w_mainFromSkid ? w_skidData : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_mainEntry (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_mainLoad),
    .i_clear (w_mainClear),
    .i_ctrl  (w_mainCtrlIn),
    .i_data  (w_mainDataIn),
    .o_valid (w_mainValid),
    .o_ctrl  (w_mainCtrl),
    .o_data  (w_mainData)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skidEntry (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skidLoad),
    .i_clear (w_skidClear),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_skidValid),
    .o_ctrl  (w_skidCtrl),
    .o_data  (w_skidData)
  );

  assign out_valid = w_mainValid;
  assign out_ctrl  = w_mainCtrl & {CTRL_W{w_mainValid}};
  assign out_data  = w_mainData;
  assign occupancy = {1'b0, w_mainValid} + {1'b0, w_skidValid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid-buffered instance and one
// single-register instance, checked against hand-computed values.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 133;
  typedef logic [DW-1:0] chk_t;

  logic          clk;
  logic          rst;
  logic          flushIn, inValid, inReady, outValid, outReady;
  logic [CW-1:0] inCtrl, outCtrl;
  logic [DW-1:0] inData, outData;
  logic [1:0]    occ;
  logic          flushIn0, inValid0, inReady0, outValid0, outReady0;
  logic [CW-1:0] inCtrl0, outCtrl0;
  logic [DW-1:0] inData0, outData0;
  logic [1:0]    occ0;

  int checkCount = 0;
  int errorCount = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flushIn),
    .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
    .occupancy(occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flushIn0),
    .in_valid(inValid0), .in_ready(inReady0), .in_ctrl(inCtrl0), .in_data(inData0),
    .out_valid(outValid0), .out_ready(outReady0), .out_ctrl(outCtrl0), .out_data(outData0),
    .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input chk_t observed, input chk_t expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input chk_t d,
                               input logic ordy, input logic fl);
    inValid  = v;
    inCtrl   = c;
    inData   = d;
    outReady = ordy;
    flushIn  = fl;
  endtask

  task automatic applyStimulus0(input logic v, input logic [CW-1:0] c, input chk_t d,
                                input logic ordy, input logic fl);
    inValid0  = v;
    inCtrl0   = c;
    inData0   = d;
    outReady0 = ordy;
    flushIn0  = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] streamCtrl;
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus0(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_valid", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("rst_ctrl", chk_t'(outCtrl), chk_t'(8'h00));
    checkOutput("rst_data", outData, '0);
    checkOutput("rst_occ", chk_t'(occ), chk_t'(2'd0));
    checkOutput("rst_inready", chk_t'(inReady), chk_t'(1'b1));
    checkOutput("rst_inready0", chk_t'(inReady0), chk_t'(1'b1));
    checkOutput("rst_occ0", chk_t'(occ0), chk_t'(2'd0));
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate, last entry carries all-ones control
    for (int i = 1; i <= 4; i++) begin
      streamCtrl = (i == 4) ? 8'hFF : 8'h11;
      applyStimulus(1'b1, streamCtrl, chk_t'(i), 1'b1, 1'b0);
      tick();
      checkOutput("stream_data", outData, chk_t'(i));
      checkOutput("stream_valid", chk_t'(outValid), chk_t'(1'b1));
      checkOutput("stream_occ", chk_t'(occ), chk_t'(2'd1));
      checkOutput("stream_inready", chk_t'(inReady), chk_t'(1'b1));
    end
    checkOutput("stream_ctrl_ff", chk_t'(outCtrl), chk_t'(8'hFF));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("bubble_valid", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("bubble_ctrl", chk_t'(outCtrl), chk_t'(8'h00));

    // Backpressure fills the skid entry, then drains in order
    applyStimulus(1'b1, 8'h22, chk_t'(8'hA), 1'b0, 1'b0);
    tick();
    checkOutput("bp_a_data", outData, chk_t'(8'hA));
    checkOutput("bp_a_occ", chk_t'(occ), chk_t'(2'd1));
    checkOutput("bp_a_inready", chk_t'(inReady), chk_t'(1'b1));
    applyStimulus(1'b1, 8'h23, chk_t'(8'hB), 1'b0, 1'b0);
    tick();
    checkOutput("bp_b_occ", chk_t'(occ), chk_t'(2'd2));
    checkOutput("bp_b_inready", chk_t'(inReady), chk_t'(1'b0));
    checkOutput("bp_b_data", outData, chk_t'(8'hA));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_data", outData, chk_t'(8'hA));
    checkOutput("stall_ctrl", chk_t'(outCtrl), chk_t'(8'h22));
    checkOutput("stall_occ", chk_t'(occ), chk_t'(2'd2));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_b_data", outData, chk_t'(8'hB));
    checkOutput("drain_b_ctrl", chk_t'(outCtrl), chk_t'(8'h23));
    checkOutput("drain_b_occ", chk_t'(occ), chk_t'(2'd1));
    checkOutput("drain_inready", chk_t'(inReady), chk_t'(1'b1));
    tick();
    checkOutput("drain_empty", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("drain_occ", chk_t'(occ), chk_t'(2'd0));

    // Flush from SKIDDED with an incoming entry
    applyStimulus(1'b1, 8'h33, chk_t'(8'h1A), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h33, chk_t'(8'h1B), 1'b0, 1'b0);
    tick();
    checkOutput("pre_flush_occ", chk_t'(occ), chk_t'(2'd2));
    applyStimulus(1'b1, 8'h44, chk_t'(8'hC), 1'b0, 1'b1);
    tick();
    checkOutput("flush_valid", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("flush_ctrl", chk_t'(outCtrl), chk_t'(8'h00));
    checkOutput("flush_occ", chk_t'(occ), chk_t'(2'd0));
    checkOutput("flush_inready", chk_t'(inReady), chk_t'(1'b1));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("flush_no_c", chk_t'(outValid), chk_t'(1'b0));

    // Flush from FULL while an accept and a deliver both happen
    applyStimulus(1'b1, 8'h55, chk_t'(8'hD), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h55, chk_t'(8'hE), 1'b1, 1'b1);
    tick();
    checkOutput("flush_full_valid", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("flush_full_occ", chk_t'(occ), chk_t'(2'd0));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("flush_full_no_e", chk_t'(outValid), chk_t'(1'b0));

    // Asynchronous reset pulse while SKIDDED, away from any clock edge
    applyStimulus(1'b1, 8'h66, chk_t'(8'h21), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h66, chk_t'(8'h22), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("pre_arst_occ", chk_t'(occ), chk_t'(2'd2));
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", chk_t'(outValid), chk_t'(1'b0));
    checkOutput("arst_ctrl", chk_t'(outCtrl), chk_t'(8'h00));
    checkOutput("arst_data", outData, '0);
    checkOutput("arst_occ", chk_t'(occ), chk_t'(2'd0));
    checkOutput("arst_inready", chk_t'(inReady), chk_t'(1'b1));
    #1 rst = 1'b0;
    applyStimulus(1'b1, 8'h77, chk_t'(8'h5), 1'b1, 1'b0);
    tick();
    checkOutput("post_arst_data", outData, chk_t'(8'h5));
    checkOutput("post_arst_valid", chk_t'(outValid), chk_t'(1'b1));
    checkOutput("post_arst_ctrl", chk_t'(outCtrl), chk_t'(8'h77));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();

    // Single-register build: combinational in_ready and no-bubble replacement
    applyStimulus0(1'b1, 8'h88, chk_t'(8'h31), 1'b0, 1'b0);
    tick();
    checkOutput("s0_valid", chk_t'(outValid0), chk_t'(1'b1));
    checkOutput("s0_data", outData0, chk_t'(8'h31));
    checkOutput("s0_occ", chk_t'(occ0), chk_t'(2'd1));
    checkOutput("s0_inready_low", chk_t'(inReady0), chk_t'(1'b0));
    applyStimulus0(1'b1, 8'h89, chk_t'(8'h32), 1'b1, 1'b0);
    #1;
    checkOutput("s0_inready_comb", chk_t'(inReady0), chk_t'(1'b1));
    tick();
    checkOutput("s0_replace_data", outData0, chk_t'(8'h32));
    checkOutput("s0_replace_valid", chk_t'(outValid0), chk_t'(1'b1));
    checkOutput("s0_replace_ctrl", chk_t'(outCtrl0), chk_t'(8'h89));
    applyStimulus0(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("s0_empty_valid", chk_t'(outValid0), chk_t'(1'b0));
    checkOutput("s0_empty_ctrl", chk_t'(outCtrl0), chk_t'(8'h00));
    checkOutput("s0_empty_occ", chk_t'(occ0), chk_t'(2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
